multi_alarm_clock_core: RTL and testbench
=========================================

// Module: multi_alarm_clock_core
// PURPOSE
//  Parametrised successor of the single-alarm digital clock core. Holds a BCD time-of-day
//  counter advanced by an internal 1 Hz divider, NUM_ALM independently enabled alarms, and
//  one ring state machine with ring timeout and snooze. Sits between the key/set logic and
//  the 7-segment scan driver; the scan driver consumes time_bcd, the buzzer consumes ring.
// PARAMETERS
//  CLK_DIV     50_000_000  clk cycles per second (>=2; benches use 4)
//  NUM_ALM     4           number of alarm slots (1..8)
//  RING_SEC    60          seconds ring stays high before auto-stop (1..255)
//  SNOOZE_SEC  300         seconds in SNOOZE before re-ring (1..1023)
// PORTS
//  clk        in   1   system clock
//  rst        in   1   synchronous reset, active-high
//  set_load   in   1   1-cycle pulse: load set_time into time counter
//  set_time   in   20  packed BCD {h_shi[1:0],h_ge[3:0],m_shi[2:0],m_ge[3:0],s_shi[2:0],s_ge[3:0]}
//  alm_wr     in   1   1-cycle pulse: write alarm slot alm_idx
//  alm_idx    in   3   slot index; values >= NUM_ALM are ignored
//  alm_hhmm   in   13  packed BCD {h_shi,h_ge,m_shi,m_ge}
//  alm_en     in   1   enable bit written with the slot
//  snooze     in   1   1-cycle pulse: snooze current ring
//  stop       in   1   1-cycle pulse: cancel ring/snooze
//  time_bcd   out  20  current time, same packing as set_time
//  sec_pulse  out  1   1-cycle pulse on each second boundary
//  ring       out  1   buzzer drive
//  ring_id    out  3   slot that triggered the active ring/snooze; 0 when IDLE
//  set_err    out  1   1-cycle pulse: rejected set_load or alm_wr
// BEHAVIOUR
//  Reset: time_bcd=00:00:00, divider=0, all slots 00:00 disabled, state IDLE, all outputs 0.
//  Divider: counts 0..CLK_DIV-1; sec_pulse=1 in cycle where div==CLK_DIV-1; wraps to 0.
//  Time: on sec_pulse advance one second, registered (visible cycle after sec_pulse).
//   s_ge 9->0 carries s_shi; s_shi 5->0 carries m_ge; m 59->00 carries hour;
//   h_ge 9->0 carries h_shi; 23:59:59 -> 00:00:00.
//  set_load: valid iff each digit<=9, s_shi/m_shi<=5, hour<=23. Valid: time<=set_time,
//   divider<=0 next cycle; wins over a coincident sec_pulse. Invalid: no change, set_err=1.
//  alm_wr: valid iff alm_idx<NUM_ALM, m_shi<=5, hour<=23, digits<=9; else set_err=1.
//   Write does not alter an in-progress RING/SNOOZE.
//  Match: evaluated on the updated time in the cycle after an advance (not after set_load);
//   match = slot enabled AND hh:mm equal AND seconds==00. Lowest matching index wins.
//  FSM (single, shared):
//   IDLE   -- match -> RING; ring_id<=idx, ring_cnt<=0
//   RING   ring=1; ring_cnt++ per sec_pulse; stop -> IDLE; snooze -> SNOOZE (cnt<=0);
//          ring_cnt==RING_SEC-1 at sec_pulse -> IDLE
//   SNOOZE ring=0; cnt++ per sec_pulse; stop -> IDLE; cnt==SNOOZE_SEC-1 at sec_pulse -> RING (cnt<=0)
//   stop beats snooze when both high. New matches ignored outside IDLE.
//   ring is a registered output: high the cycle after entering RING.
//  Reset mid-operation: everything returns to reset values on the next clk edge.
// STRUCTURE
//  Shared package clock_pkg: BCD field widths/offsets of the 20-bit and 13-bit packings,
//   max-digit constants, FSM state encoding (IDLE/RING/SNOOZE), bcd_valid functions.
//  Sub-module bcd_time_counter: divider + BCD counter + load/validate; the top holds the
//   alarm register file, match priority encoder and ring FSM.
// TESTING (CLK_DIV=4, NUM_ALM=4, RING_SEC=3, SNOOZE_SEC=2)
//  1 Load 23:59:58, run 2 sec_pulse -> time_bcd 23:59:59 then 00:00:00.
//  2 set_load 24:00:00 and 12:60:00 -> set_err pulses, time unchanged; 12:34:56 accepted.
//  3 Slot2=07:00 en, slot1=07:00 en, load 06:59:59 -> after sec_pulse ring=1, ring_id=1;
//    no stop -> ring drops after 3 sec_pulse, ring_id=0.
//  4 Ring slot0, snooze -> ring=0 for 2 sec_pulse, then ring=1; stop -> IDLE, ring=0.
//  5 Disabled slot at matching time -> no ring; alm_idx=5 write -> set_err, no slot change.
//  6 set_load coincident with sec_pulse -> loaded value, divider restarts; rst while RING -> all 0.

Source files
------------

// File: rtl/clock_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : clock_pkg                                                         |
// | Shared BCD packing layout, digit limits, ring FSM encoding and validators.  |
// | Rev     : 1.0                                                               |
// +----------------------------------------------------------------------------+
package clock_pkg;

    localparam int c_time_w    = 20;
    localparam int c_hhmm_w    = 13;

    // 20-bit time: {h_shi[1:0],h_ge[3:0],m_shi[2:0],m_ge[3:0],s_shi[2:0],s_ge[3:0]}
    localparam int c_s_ge_lsb  = 0;
    localparam int c_s_shi_lsb = 4;
    localparam int c_m_ge_lsb  = 7;
    localparam int c_m_shi_lsb = 11;
    localparam int c_h_ge_lsb  = 14;
    localparam int c_h_shi_lsb = 18;
    // the 13-bit hh:mm packing is the upper part of the time packing
    localparam int c_hhmm_lsb  = c_m_ge_lsb;

    localparam logic [3:0] c_max_ge      = 4'd9;
    localparam logic [2:0] c_max_shi     = 3'd5;
    localparam logic [1:0] c_max_h_shi   = 2'd2;
    localparam logic [3:0] c_max_h_ge_20 = 4'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2
    } ring_state_t;

    function automatic logic hour_valid(input logic [1:0] h_shi, input logic [3:0] h_ge);
        return (h_ge <= c_max_ge) &&
               ((h_shi < c_max_h_shi) || ((h_shi == c_max_h_shi) && (h_ge <= c_max_h_ge_20)));
    endfunction

    function automatic logic hhmm_valid(input logic [c_hhmm_w-1:0] a);
        return hour_valid(a[12:11], a[10:7]) && (a[6:4] <= c_max_shi) && (a[3:0] <= c_max_ge);
    endfunction

    function automatic logic time_valid(input logic [c_time_w-1:0] t);
        return hhmm_valid(t[c_time_w-1:c_hhmm_lsb]) && (t[6:4] <= c_max_shi) && (t[3:0] <= c_max_ge);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_time_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : bcd_time_counter                                                   |
// | 1 Hz divider plus BCD time-of-day counter with validated synchronous load.  |
// | Rev    : 1.0                                                                |
// +----------------------------------------------------------------------------+
module bcd_time_counter import clock_pkg::*; #(
    parameter int CLK_DIV = 50_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_set_load,
    input  logic [c_time_w-1:0] i_set_time,
    output logic [c_time_w-1:0] o_time_bcd,
    output logic                o_sec_pulse,
    output logic                o_adv,
    output logic                o_load_err
);

    localparam int                 c_div_w   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_div_w-1:0] c_div_max = c_div_w'(CLK_DIV - 1);

    logic [c_div_w-1:0]  r_div;
    logic [c_time_w-1:0] r_time;
    logic                r_adv;
    logic                r_load_err;
    logic                w_load_ok;
    logic [c_time_w-1:0] w_next;
    logic [3:0]          w_s_ge, w_m_ge, w_h_ge;
    logic [2:0]          w_s_shi, w_m_shi;
    logic [1:0]          w_h_shi;

    assign o_sec_pulse = (r_div == c_div_max);
    assign w_load_ok   = time_valid(i_set_time);
    assign o_time_bcd  = r_time;
    assign o_adv       = r_adv;
    assign o_load_err  = r_load_err;

    // one-second increment with the BCD carry ripple, 23:59:59 wraps to 00:00:00
    always_comb begin
        w_s_ge  = r_time[c_s_ge_lsb  +: 4];
        w_s_shi = r_time[c_s_shi_lsb +: 3];
        w_m_ge  = r_time[c_m_ge_lsb  +: 4];
        w_m_shi = r_time[c_m_shi_lsb +: 3];
        w_h_ge  = r_time[c_h_ge_lsb  +: 4];
        w_h_shi = r_time[c_h_shi_lsb +: 2];
        if (w_s_ge != c_max_ge) begin
            w_s_ge = w_s_ge + 4'd1;
        end else begin
            w_s_ge = '0;
            if (w_s_shi != c_max_shi) begin
                w_s_shi = w_s_shi + 3'd1;
            end else begin
                w_s_shi = '0;
                if (w_m_ge != c_max_ge) begin
                    w_m_ge = w_m_ge + 4'd1;
                end else begin
                    w_m_ge = '0;
                    if (w_m_shi != c_max_shi) begin
                        w_m_shi = w_m_shi + 3'd1;
                    end else begin
                        w_m_shi = '0;
                        if ((w_h_shi == c_max_h_shi) && (w_h_ge == c_max_h_ge_20)) begin
                            w_h_shi = '0;
                            w_h_ge  = '0;
                        end else if (w_h_ge == c_max_ge) begin
                            w_h_ge  = '0;
                            w_h_shi = w_h_shi + 2'd1;
                        end else begin
                            w_h_ge = w_h_ge + 4'd1;
                        end
                    end
                end
            end
        end
        w_next = {w_h_shi, w_h_ge, w_m_shi, w_m_ge, w_s_shi, w_s_ge};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div      <= '0;
            r_time     <= '0;
            r_adv      <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_load_err <= i_set_load & ~w_load_ok;
            r_adv      <= o_sec_pulse & ~(i_set_load & w_load_ok);
            if (i_set_load && w_load_ok) begin
                r_time <= i_set_time;
                r_div  <= '0;
            end else begin
                if (o_sec_pulse) begin
                    r_time <= w_next;
                end
                r_div <= o_sec_pulse ? '0 : r_div + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/multi_alarm_clock_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : multi_alarm_clock_core                                             |
// | BCD clock with NUM_ALM alarm slots and a shared ring/snooze state machine.  |
// | Rev    : 1.0                                                                |
// +----------------------------------------------------------------------------+
module multi_alarm_clock_core import clock_pkg::*; #(
    parameter int CLK_DIV    = 50_000_000,
    parameter int NUM_ALM    = 4,
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                set_load,
    input  logic [c_time_w-1:0] set_time,
    input  logic                alm_wr,
    input  logic [2:0]          alm_idx,
    input  logic [c_hhmm_w-1:0] alm_hhmm,
    input  logic                alm_en,
    input  logic                snooze,
    input  logic                stop,
    output logic [c_time_w-1:0] time_bcd,
    output logic                sec_pulse,
    output logic                ring,
    output logic [2:0]          ring_id,
    output logic                set_err
);

    localparam logic [9:0] c_ring_last = 10'(RING_SEC - 1);
    localparam logic [9:0] c_snz_last  = 10'(SNOOZE_SEC - 1);

    logic                w_adv;
    logic                w_load_err;
    logic                w_alm_ok;
    logic                r_alm_err;
    logic [c_hhmm_w-1:0] r_alm_hhmm [NUM_ALM];
    logic [NUM_ALM-1:0]  r_alm_en;
    logic [NUM_ALM-1:0]  w_hit;
    logic                w_match;
    logic [2:0]          w_match_idx;
    ring_state_t         r_state;
    logic [9:0]          r_cnt;
    logic                r_ring;
    logic [2:0]          r_ring_id;

    bcd_time_counter #(
        .CLK_DIV (CLK_DIV)
    ) u_time (
        .clk         (clk),
        .rst         (rst),
        .i_set_load  (set_load),
        .i_set_time  (set_time),
        .o_time_bcd  (time_bcd),
        .o_sec_pulse (sec_pulse),
        .o_adv       (w_adv),
        .o_load_err  (w_load_err)
    );

    assign w_alm_ok = ({1'b0, alm_idx} < 4'(NUM_ALM)) && hhmm_valid(alm_hhmm);
    assign set_err  = w_load_err | r_alm_err;
    assign ring     = r_ring;
    assign ring_id  = r_ring_id;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_alm_err <= 1'b0;
            r_alm_en  <= '0;
            for (int i = 0; i < NUM_ALM; i++) begin
                r_alm_hhmm[i] <= '0;
            end
        end else begin
            r_alm_err <= alm_wr & ~w_alm_ok;
            for (int i = 0; i < NUM_ALM; i++) begin
                if (alm_wr && w_alm_ok && (alm_idx == 3'(i))) begin
                    r_alm_hhmm[i] <= alm_hhmm;
                    r_alm_en[i]   <= alm_en;
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_ALM; gi++) begin : g_match
            assign w_hit[gi] = r_alm_en[gi] &&
                               (r_alm_hhmm[gi] == time_bcd[c_time_w-1:c_hhmm_lsb]) &&
                               (time_bcd[c_hhmm_lsb-1:0] == '0);
        end
    endgenerate

    // scan downwards so the lowest matching slot is the one left standing
    always_comb begin
        w_match_idx = '0;
        for (int i = NUM_ALM - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_match_idx = 3'(i);
            end
        end
        w_match = |w_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_ring    <= 1'b0;
            r_ring_id <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_adv && w_match) begin
                        r_state   <= ST_RING;
                        r_cnt     <= '0;
                        r_ring    <= 1'b1;
                        r_ring_id <= w_match_idx;
                    end
                end
                ST_RING: begin
                    if (stop || (sec_pulse && !snooze && (r_cnt == c_ring_last))) begin
                        r_state   <= ST_IDLE;
                        r_ring    <= 1'b0;
                        r_ring_id <= '0;
                    end else if (snooze) begin
                        r_state <= ST_SNOOZE;
                        r_cnt   <= '0;
                        r_ring  <= 1'b0;
                    end else if (sec_pulse) begin
                        r_cnt <= r_cnt + 10'd1;
                    end
                end
                ST_SNOOZE: begin
                    if (stop) begin
                        r_state   <= ST_IDLE;
                        r_ring    <= 1'b0;
                        r_ring_id <= '0;
                    end else if (sec_pulse) begin
                        if (r_cnt == c_snz_last) begin
                            r_state <= ST_RING;
                            r_cnt   <= '0;
                            r_ring  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 10'd1;
                        end
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_cnt     <= '0;
                    r_ring    <= 1'b0;
                    r_ring_id <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_alarm_clock_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_multi_alarm_clock_core                                          |
// | Directed, table-driven and randomized checks against a seconds-based model. |
// | Rev    : 1.0                                                                |
// +----------------------------------------------------------------------------+
module tb_multi_alarm_clock_core;

    localparam int CLK_DIV    = 4;
    localparam int NUM_ALM    = 4;
    localparam int RING_SEC   = 3;
    localparam int SNOOZE_SEC = 2;
    localparam int DAY        = 86400;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        set_load = 1'b0;
    logic [19:0] set_time = '0;
    logic        alm_wr = 1'b0;
    logic [2:0]  alm_idx = '0;
    logic [12:0] alm_hhmm = '0;
    logic        alm_en = 1'b0;
    logic        snooze = 1'b0;
    logic        stop = 1'b0;
    logic [19:0] time_bcd;
    logic        sec_pulse;
    logic        ring;
    logic [2:0]  ring_id;
    logic        set_err;

    multi_alarm_clock_core #(
        .CLK_DIV    (CLK_DIV),
        .NUM_ALM    (NUM_ALM),
        .RING_SEC   (RING_SEC),
        .SNOOZE_SEC (SNOOZE_SEC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .set_load  (set_load),
        .set_time  (set_time),
        .alm_wr    (alm_wr),
        .alm_idx   (alm_idx),
        .alm_hhmm  (alm_hhmm),
        .alm_en    (alm_en),
        .snooze    (snooze),
        .stop      (stop),
        .time_bcd  (time_bcd),
        .sec_pulse (sec_pulse),
        .ring      (ring),
        .ring_id   (ring_id),
        .set_err   (set_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [19:0] enc(input int secs);
        int h, m, s;
        h = secs / 3600;
        m = (secs / 60) % 60;
        s = secs % 60;
        return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [12:0] enc_hm(input int h, input int m);
        return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10)};
    endfunction

    function automatic bit hm_ok(input logic [12:0] a);
        return (int'(a[10:7]) <= 9) && (int'(a[3:0]) <= 9) && (int'(a[6:4]) <= 5) &&
               (int'(a[12:11]) * 10 + int'(a[10:7]) <= 23);
    endfunction

    function automatic int hm_min(input logic [12:0] a);
        return (int'(a[12:11]) * 10 + int'(a[10:7])) * 60 + int'(a[6:4]) * 10 + int'(a[3:0]);
    endfunction

    function automatic bit t_ok(input logic [19:0] t);
        return hm_ok(t[19:7]) && (int'(t[6:4]) <= 5) && (int'(t[3:0]) <= 9);
    endfunction

    function automatic int t_dec(input logic [19:0] t);
        return hm_min(t[19:7]) * 60 + int'(t[6:4]) * 10 + int'(t[3:0]);
    endfunction

    // Reference model: time as seconds-of-day, alarms as minutes-of-day,
    // ring/snooze as a countdown of seconds remaining.
    int m_div, m_sec, m_left, m_id, m_mode, m_hit;
    int m_alm [NUM_ALM];
    bit m_en  [NUM_ALM];
    bit m_chk, m_err, m_sp;

    always @(posedge clk) begin
        if (rst) begin
            m_div = 0; m_sec = 0; m_left = 0; m_id = 0; m_mode = 0;
            m_chk = 0; m_err = 0;
            for (int i = 0; i < NUM_ALM; i++) begin
                m_alm[i] = 0;
                m_en[i]  = 0;
            end
        end else begin
            m_sp  = (m_div == CLK_DIV - 1);
            m_hit = -1;
            if (m_chk)
                for (int i = NUM_ALM - 1; i >= 0; i--)
                    if (m_en[i] && m_alm[i] * 60 == m_sec) m_hit = i;
            case (m_mode)
                0: if (m_hit >= 0) begin m_mode = 1; m_left = RING_SEC; m_id = m_hit; end
                1: begin
                    if (stop) m_mode = 0;
                    else if (snooze) begin m_mode = 2; m_left = SNOOZE_SEC; end
                    else if (m_sp) begin m_left--; if (m_left == 0) m_mode = 0; end
                end
                default: begin
                    if (stop) m_mode = 0;
                    else if (m_sp) begin
                        m_left--;
                        if (m_left == 0) begin m_mode = 1; m_left = RING_SEC; end
                    end
                end
            endcase
            m_err = (set_load && !t_ok(set_time)) ||
                    (alm_wr && !(int'(alm_idx) < NUM_ALM && hm_ok(alm_hhmm)));
            if (alm_wr && int'(alm_idx) < NUM_ALM && hm_ok(alm_hhmm)) begin
                m_alm[int'(alm_idx)] = hm_min(alm_hhmm);
                m_en[int'(alm_idx)]  = alm_en;
            end
            if (set_load && t_ok(set_time)) begin
                m_sec = t_dec(set_time);
                m_div = 0;
                m_chk = 0;
            end else begin
                m_chk = m_sp;
                if (m_sp) m_sec = (m_sec + 1) % DAY;
                m_div = (m_div + 1) % CLK_DIV;
            end
        end
    end

    bit chk_on = 0;
    always @(negedge clk) begin
        if (chk_on)
            check("model", {time_bcd, sec_pulse, ring, ring_id, set_err},
                  {enc(m_sec), m_div == CLK_DIV - 1, m_mode == 1,
                   3'((m_mode == 0) ? 0 : m_id), m_err});
    end

    task automatic pulse_load(input logic [19:0] t);
        set_load = 1'b1; set_time = t;
        @(negedge clk);
        set_load = 1'b0;
    endtask

    task automatic pulse_alm(input int idx, input logic [12:0] hm, input logic en);
        alm_wr = 1'b1; alm_idx = 3'(idx); alm_hhmm = hm; alm_en = en;
        @(negedge clk);
        alm_wr = 1'b0;
    endtask

    task automatic wait_sec();
        bit seen;
        seen = 0;
        for (int i = 0; i < 2 * CLK_DIV + 1 && !seen; i++) begin
            @(negedge clk);
            seen = sec_pulse;
        end
        if (!seen) begin
            n_chk++;
            $display("FAIL sec_wait: no sec_pulse within %0d cycles", 2 * CLK_DIV + 1);
        end
    endtask

    typedef struct {
        logic [19:0] t;
        logic        err;
        logic [19:0] exp_t;
    } ld_vec_t;

    ld_vec_t ld_tab [9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r, j, n;
        ld_tab[0] = '{enc(12*3600+34*60+56), 1'b0, enc(12*3600+34*60+56)};
        ld_tab[1] = '{{2'd2,4'd4,3'd0,4'd0,3'd0,4'd0}, 1'b1, enc(12*3600+34*60+56)};
        ld_tab[2] = '{{2'd1,4'd2,3'd6,4'd0,3'd0,4'd0}, 1'b1, enc(12*3600+34*60+56)};
        ld_tab[3] = '{enc(0), 1'b0, enc(0)};
        ld_tab[4] = '{{2'd0,4'd9,3'd5,4'd10,3'd0,4'd0}, 1'b1, enc(0)};
        ld_tab[5] = '{{2'd0,4'd5,3'd0,4'd0,3'd6,4'd0}, 1'b1, enc(0)};
        ld_tab[6] = '{enc(DAY-1), 1'b0, enc(DAY-1)};
        ld_tab[7] = '{enc(19*3600), 1'b0, enc(19*3600)};
        ld_tab[8] = '{{2'd3,4'd0,3'd0,4'd0,3'd0,4'd0}, 1'b1, enc(19*3600)};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_on = 1;
        check("rst_time", time_bcd, 0);
        check("rst_outs", {sec_pulse, ring, ring_id, set_err}, 0);

        // midnight roll-over
        pulse_load(enc(DAY-2));
        check("t1_load", time_bcd, enc(DAY-2));
        wait_sec(); @(negedge clk);
        check("t1_235959", time_bcd, enc(DAY-1));
        wait_sec(); @(negedge clk);
        check("t1_wrap", time_bcd, 0);

        foreach (ld_tab[i]) begin
            pulse_load(ld_tab[i].t);
            check("ld_err", set_err, ld_tab[i].err);
            check("ld_time", time_bcd, ld_tab[i].exp_t);
        end

        // two slots at 07:00, lower index wins, auto-stop after RING_SEC
        pulse_alm(2, enc_hm(7, 0), 1'b1);
        pulse_alm(1, enc_hm(7, 0), 1'b1);
        check("alm_ok_err", set_err, 0);
        pulse_load(enc(6*3600+59*60+59));
        wait_sec(); @(negedge clk);
        check("t3_time", time_bcd, enc(7*3600));
        @(negedge clk);
        check("t3_ring", ring, 1);
        check("t3_id", ring_id, 1);
        wait_sec(); wait_sec(); wait_sec();
        check("t3_ring_last", ring, 1);
        @(negedge clk);
        check("t3_ring_off", {ring, ring_id}, 0);

        // snooze then re-ring, then stop+snooze together
        pulse_alm(0, enc_hm(8, 0), 1'b1);
        pulse_load(enc(7*3600+59*60+59));
        wait_sec(); @(negedge clk); @(negedge clk);
        check("t4_ring", {ring, ring_id}, 4'b1000);
        snooze = 1'b1; @(negedge clk); snooze = 1'b0;
        check("t4_snz", ring, 0);
        wait_sec();
        check("t4_snz1", ring, 0);
        wait_sec();
        check("t4_snz2", ring, 0);
        @(negedge clk);
        check("t4_rering", ring, 1);
        stop = 1'b1; snooze = 1'b1; @(negedge clk); stop = 1'b0; snooze = 1'b0;
        check("t4_stop", ring, 0);
        wait_sec(); wait_sec(); wait_sec(); @(negedge clk);
        check("t4_stays_idle", {ring, ring_id}, 0);

        // disabled slot, out-of-range and invalid writes
        pulse_alm(3, enc_hm(9, 0), 1'b0);
        check("t5_wr_ok", set_err, 0);
        pulse_alm(5, enc_hm(9, 0), 1'b1);
        check("t5_idx_err", set_err, 1);
        pulse_alm(3, {2'd2, 4'd4, 3'd0, 4'd0}, 1'b1);
        check("t5_hhmm_err", set_err, 1);
        pulse_load(enc(8*3600+59*60+59));
        wait_sec(); @(negedge clk);
        check("t5_time", time_bcd, enc(9*3600));
        @(negedge clk); @(negedge clk);
        check("t5_no_ring", ring, 0);

        // load coincident with sec_pulse, then divider restart on a mid-second load
        wait_sec();
        pulse_load(enc(10*3600+20*60+30));
        check("t6_coinc", {time_bcd, sec_pulse}, {enc(10*3600+20*60+30), 1'b0});
        wait_sec(); @(negedge clk); @(negedge clk);
        pulse_load(enc(11*3600));
        n = 0;
        while (!sec_pulse && n < 20) begin @(negedge clk); n++; end
        check("t6_div_restart", n, CLK_DIV - 1);

        // reset while ringing
        pulse_load(enc(7*3600+59*60+59));
        wait_sec(); @(negedge clk); @(negedge clk);
        check("t6_ring", ring, 1);
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        check("t6_rst", {time_bcd, sec_pulse, ring, ring_id, set_err}, 0);
        pulse_load(enc(7*3600+59*60+59));
        wait_sec(); @(negedge clk); @(negedge clk);
        check("t6_alm_cleared", ring, 0);

        // randomized traffic, checked cycle by cycle against the model
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            set_load = 1'b0; alm_wr = 1'b0; snooze = 1'b0; stop = 1'b0; rst = 1'b0;
            r = int'($urandom_range(0, 999));
            if (k % 50 == 0) begin
                j = int'($urandom_range(0, NUM_ALM - 1));
                set_load = 1'b1;
                set_time = enc((m_alm[j] * 60 + DAY - int'($urandom_range(1, 4))) % DAY);
            end else if (r < 20) begin
                set_load = 1'b1;
                set_time = (r < 10) ? enc(int'($urandom_range(0, DAY - 1))) : 20'($urandom);
            end else if (r < 50) begin
                alm_wr   = 1'b1;
                alm_idx  = 3'($urandom_range(0, 7));
                alm_hhmm = (r < 42) ? enc_hm(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)))
                                    : 13'($urandom);
                alm_en   = ($urandom_range(0, 3) != 0);
            end else if (r < 70) begin
                snooze = 1'b1;
                if (r < 73) stop = 1'b1;
            end else if (r < 80) begin
                stop = 1'b1;
            end else if (r < 82) begin
                rst = 1'b1;
            end
        end
        @(negedge clk);
        set_load = 1'b0; alm_wr = 1'b0; snooze = 1'b0; stop = 1'b0; rst = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
